// File: rtl/jtag_tap_param.sv
// jtag_tap_param -- parameterised IEEE 1149.1 TAP controller with IR, BYPASS,
// IDCODE, boundary-scan and user data registers.
//
// Ports:
//   tck          test clock; FSM and registers on rising edge, tdo on falling
//   rst_n        asynchronous active-low reset
//   tdi, tms     serial data in, mode select
//   tdo, tdo_en  serial data out and its enable (valid in Shift-IR/DR only)
//   bsr_cap_i    pin values loaded into the BSR on Capture-DR
//   bsr_upd_o    BSR update latch
//   bsr_drive_o  high while the active instruction is EXTEST or INTEST
//   usr_cap_i    value loaded into the user register on Capture-DR
//   usr_upd_o    user register update latch
//   usr_strb_o   one-tck pulse on each user update
//   ir_o         active instruction
module jtag_tap_param #(
    parameter int unsigned IR_W   = 4,
    parameter int unsigned BSR_W  = 8,
    parameter int unsigned USR_W  = 16,
    parameter logic [31:0] IDCODE = 32'h1BDA_0001
) (
    input  logic             tck,
    input  logic             rst_n,
    input  logic             tdi,
    input  logic             tms,
    output logic             tdo,
    output logic             tdo_en,
    input  logic [BSR_W-1:0] bsr_cap_i,
    output logic [BSR_W-1:0] bsr_upd_o,
    output logic             bsr_drive_o,
    input  logic [USR_W-1:0] usr_cap_i,
    output logic [USR_W-1:0] usr_upd_o,
    output logic             usr_strb_o,
    output logic [IR_W-1:0]  ir_o
);

    localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(1);
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(2);
    localparam logic [IR_W-1:0] OP_INTEST  = IR_W'(3);
    localparam logic [IR_W-1:0] OP_USER    = IR_W'(4);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS, DR_IDCODE, DR_BSR, DR_USR
    } dr_sel_t;

    tap_state_t       state, state_nxt;
    dr_sel_t          dr_sel;

    logic [IR_W-1:0]  ir_sr;
    logic             bypass_sr;
    logic [31:0]      id_sr;
    logic [BSR_W-1:0] bsr_sr, bsr_shift;
    logic [USR_W-1:0] usr_sr, usr_shift;
    logic             dr_lsb;

    // ---------------- TAP state register ----------------
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) state <= S_TLR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_TLR;
        unique case (state)
            S_TLR:      state_nxt = tms ? S_TLR      : S_RTI;
            S_RTI:      state_nxt = tms ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   state_nxt = tms ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   state_nxt = tms ? S_EXIT1_DR : S_SHIFT_DR;
            S_SHIFT_DR: state_nxt = tms ? S_EXIT1_DR : S_SHIFT_DR;
            S_EXIT1_DR: state_nxt = tms ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: state_nxt = tms ? S_EXIT2_DR : S_PAUSE_DR;
            S_EXIT2_DR: state_nxt = tms ? S_UPD_DR   : S_SHIFT_DR;
            S_UPD_DR:   state_nxt = tms ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   state_nxt = tms ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   state_nxt = tms ? S_EXIT1_IR : S_SHIFT_IR;
            S_SHIFT_IR: state_nxt = tms ? S_EXIT1_IR : S_SHIFT_IR;
            S_EXIT1_IR: state_nxt = tms ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: state_nxt = tms ? S_EXIT2_IR : S_PAUSE_IR;
            S_EXIT2_IR: state_nxt = tms ? S_UPD_IR   : S_SHIFT_IR;
            S_UPD_IR:   state_nxt = tms ? S_SEL_DR   : S_RTI;
            default:    state_nxt = S_TLR;
        endcase
    end

    // ---------------- instruction decode ----------------
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_o)
            OP_EXTEST, OP_SAMPLE, OP_INTEST: dr_sel = DR_BSR;
            OP_IDCODE:                       dr_sel = DR_IDCODE;
            OP_USER:                         dr_sel = DR_USR;
            default:                         dr_sel = DR_BYPASS;
        endcase
    end

    assign bsr_drive_o = (ir_o == OP_EXTEST) || (ir_o == OP_INTEST);

    // Shift-right images written element-wise so a 1-bit register still works.
    always_comb begin
        bsr_shift            = bsr_sr >> 1;
        bsr_shift[BSR_W-1]   = tdi;
        usr_shift            = usr_sr >> 1;
        usr_shift[USR_W-1]   = tdi;
    end

    always_comb begin
        dr_lsb = 1'b0;
        case (dr_sel)
            DR_BYPASS: dr_lsb = bypass_sr;
            DR_IDCODE: dr_lsb = id_sr[0];
            DR_BSR:    dr_lsb = bsr_sr[0];
            DR_USR:    dr_lsb = usr_sr[0];
            default:   dr_lsb = 1'b0;
        endcase
    end

    // ---------------- shift / capture / update registers ----------------
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ir_sr      <= '0;
            ir_o       <= OP_IDCODE;
            bypass_sr  <= 1'b0;
            id_sr      <= '0;
            bsr_sr     <= '0;
            usr_sr     <= '0;
            bsr_upd_o  <= '0;
            usr_upd_o  <= '0;
            usr_strb_o <= 1'b0;
        end else begin
            usr_strb_o <= 1'b0;
            // Clear on the edge entering TLR (and on every edge spent there), so
            // the outputs already read as reset while the FSM sits in TLR.
            if (state_nxt == S_TLR) begin
                ir_o      <= OP_IDCODE;
                bsr_upd_o <= '0;
                usr_upd_o <= '0;
            end else begin
                case (state)
                    S_CAP_IR:   ir_sr <= IR_CAPTURE;
                    S_SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]};
                    S_UPD_IR:   ir_o  <= ir_sr;
                    S_CAP_DR: begin
                        case (dr_sel)
                            DR_BYPASS: bypass_sr <= 1'b0;
                            DR_IDCODE: id_sr     <= IDCODE;
                            DR_BSR:    bsr_sr    <= bsr_cap_i;
                            DR_USR:    usr_sr    <= usr_cap_i;
                            default:   bypass_sr <= 1'b0;
                        endcase
                    end
                    S_SHIFT_DR: begin
                        case (dr_sel)
                            DR_BYPASS: bypass_sr <= tdi;
                            DR_IDCODE: id_sr     <= {tdi, id_sr[31:1]};
                            DR_BSR:    bsr_sr    <= bsr_shift;
                            DR_USR:    usr_sr    <= usr_shift;
                            default:   bypass_sr <= tdi;
                        endcase
                    end
                    S_UPD_DR: begin
                        if (dr_sel == DR_BSR) begin
                            bsr_upd_o <= bsr_sr;
                        end else if (dr_sel == DR_USR) begin
                            usr_upd_o  <= usr_sr;
                            usr_strb_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- falling-edge output stage ----------------
    always_ff @(negedge tck or negedge rst_n) begin
        if (!rst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (state == S_SHIFT_IR) begin
            tdo    <= ir_sr[0];
            tdo_en <= 1'b1;
        end else if (state == S_SHIFT_DR) begin
            tdo    <= dr_lsb;
            tdo_en <= 1'b1;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb_jtag_tap_param -- directed, table-driven bench for jtag_tap_param.
module tb_jtag_tap_param;

    localparam int unsigned IR_W  = 4;
    localparam int unsigned BSR_W = 8;
    localparam int unsigned USR_W = 16;

    logic             tck = 1'b0;
    logic             rst_n = 1'b1;
    logic             tdi = 1'b0;
    logic             tms = 1'b1;
    logic             tdo, tdo_en;
    logic [BSR_W-1:0] bsr_cap_i = '0;
    logic [BSR_W-1:0] bsr_upd_o;
    logic             bsr_drive_o;
    logic [USR_W-1:0] usr_cap_i = '0;
    logic [USR_W-1:0] usr_upd_o;
    logic             usr_strb_o;
    logic [IR_W-1:0]  ir_o;

    jtag_tap_param #(
        .IR_W   (IR_W),
        .BSR_W  (BSR_W),
        .USR_W  (USR_W),
        .IDCODE (32'h1BDA_0001)
    ) dut (
        .tck         (tck),
        .rst_n       (rst_n),
        .tdi         (tdi),
        .tms         (tms),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .bsr_cap_i   (bsr_cap_i),
        .bsr_upd_o   (bsr_upd_o),
        .bsr_drive_o (bsr_drive_o),
        .usr_cap_i   (usr_cap_i),
        .usr_upd_o   (usr_upd_o),
        .usr_strb_o  (usr_strb_o),
        .ir_o        (ir_o)
    );

    always #5 tck = ~tck;

    int errors   = 0;
    int checks   = 0;
    int strb_cnt = 0;

    always @(negedge tck) if (usr_strb_o === 1'b1) strb_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  bsr_cap;
        logic [15:0] usr_cap;
        int          len;
        logic [31:0] upd;
        logic [7:0]  pad;
        logic        drive;
        logic [7:0]  exp_bsr;
        logic [15:0] exp_usr;
        int          exp_strb;
        logic [31:0] exp_cap;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive tms/tdi for one rising edge; return just after the next falling edge.
    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From Run-Test/Idle.
    task automatic to_shift_dr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic to_shift_ir();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Shift n bits; the last edge leaves to Exit1.
    task automatic shift(input int n, input logic [63:0] din,
                         output logic [63:0] dout, output logic en_ok);
        dout  = '0;
        en_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            if (tdo_en !== 1'b1) en_ok = 1'b0;
            tick(i == n - 1, din[i]);
        end
    endtask

    // Exit1 -> Update -> Run-Test/Idle (update happens on the last edge).
    task automatic finish_update();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] op, output logic [3:0] ir_cap);
        logic [63:0] d;
        logic        en;
        to_shift_ir();
        shift(IR_W, 64'(op), d, en);
        finish_update();
        ir_cap = d[3:0];
    endtask

    task automatic check_idcode(input string name);
        logic [63:0] d;
        logic        en;
        to_shift_dr();
        shift(32, 64'd0, d, en);
        chk(name, d[31:0], 32'h1BDA_0001);
        chk({name, "_en"}, 32'(en), 32'd1);
        finish_update();
    endtask

    initial begin
        logic [63:0] dout, dout2, din, mask;
        logic [3:0]  irc;
        logic        en;
        int          s0;

        vecs[0] = '{4'h2, 8'hA5, 16'h0000, 8,  32'h0000_003C, 8'h69, 1'b0, 8'h3C, 16'h0000, 0, 32'h0000_00A5};
        vecs[1] = '{4'h0, 8'h5A, 16'h0000, 8,  32'h0000_00C3, 8'h96, 1'b1, 8'hC3, 16'h0000, 0, 32'h0000_005A};
        vecs[2] = '{4'h4, 8'h00, 16'h1234, 16, 32'h0000_BEEF, 8'hA5, 1'b0, 8'hC3, 16'hBEEF, 1, 32'h0000_1234};
        vecs[3] = '{4'h1, 8'h00, 16'h0000, 32, 32'h0000_0000, 8'h5C, 1'b0, 8'hC3, 16'hBEEF, 0, 32'h1BDA_0001};
        vecs[4] = '{4'hF, 8'h00, 16'h0000, 1,  32'h0000_0001, 8'hD2, 1'b0, 8'hC3, 16'hBEEF, 0, 32'h0000_0000};
        vecs[5] = '{4'hA, 8'h00, 16'h0000, 1,  32'h0000_0000, 8'h4B, 1'b0, 8'hC3, 16'hBEEF, 0, 32'h0000_0000};
        vecs[6] = '{4'h3, 8'h0F, 16'h0000, 8,  32'h0000_00F0, 8'hE1, 1'b1, 8'hF0, 16'hBEEF, 0, 32'h0000_000F};
        vecs[7] = '{4'h5, 8'h00, 16'h0000, 1,  32'h0000_0001, 8'h33, 1'b0, 8'hF0, 16'hBEEF, 0, 32'h0000_0000};

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge tck);
        #1 rst_n = 1'b1;
        chk("rst_ir_o",      32'(ir_o),        32'h1);
        chk("rst_bsr_upd",   32'(bsr_upd_o),   32'h0);
        chk("rst_usr_upd",   32'(usr_upd_o),   32'h0);
        chk("rst_usr_strb",  32'(usr_strb_o),  32'h0);
        chk("rst_bsr_drive", 32'(bsr_drive_o), 32'h0);
        chk("rst_tdo",       32'(tdo),         32'h0);
        chk("rst_tdo_en",    32'(tdo_en),      32'h0);

        // IDCODE straight out of reset
        tick(1'b0, 1'b0);
        check_idcode("reset_idcode");

        // IR capture pattern from reset, and instruction table
        for (int v = 0; v < 8; v++) begin
            bsr_cap_i = vecs[v].bsr_cap;
            usr_cap_i = vecs[v].usr_cap;
            load_ir(vecs[v].op, irc);
            chk("ir_capture", 32'(irc), 32'h1);
            chk("ir_o", 32'(ir_o), 32'(vecs[v].op));
            chk("bsr_drive", 32'(bsr_drive_o), 32'(vecs[v].drive));
            s0   = strb_cnt;
            din  = (64'(vecs[v].upd) << 8) | 64'(vecs[v].pad);
            mask = (64'd1 << vecs[v].len) - 64'd1;
            to_shift_dr();
            shift(vecs[v].len + 8, din, dout, en);
            chk("dr_capture", 32'(dout & mask), vecs[v].exp_cap);
            chk("dr_length", 32'((dout >> vecs[v].len) & 64'hFF), 32'(vecs[v].pad));
            chk("dr_tdo_en", 32'(en), 32'd1);
            finish_update();
            chk("bsr_upd", 32'(bsr_upd_o), 32'(vecs[v].exp_bsr));
            chk("usr_upd", 32'(usr_upd_o), 32'(vecs[v].exp_usr));
            chk("usr_strb_count", 32'(strb_cnt - s0), 32'(vecs[v].exp_strb));
            chk("idle_tdo_en", 32'(tdo_en), 32'd0);
        end

        // USER shift split by a pause: contents held across Pause/Exit
        usr_cap_i = 16'h0F0F;
        load_ir(4'h4, irc);
        s0 = strb_cnt;
        to_shift_dr();
        shift(8, 64'hA5, dout, en);
        tick(1'b0, 1'b1);
        chk("pause_tdo_en", 32'(tdo_en), 32'd0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        shift(8, 64'h5A, dout2, en);
        finish_update();
        chk("pause_out_lo", 32'(dout[7:0]),  32'h0F);
        chk("pause_out_hi", 32'(dout2[7:0]), 32'h0F);
        chk("pause_usr_upd", 32'(usr_upd_o), 32'h5AA5);
        chk("pause_strb", 32'(strb_cnt - s0), 32'd1);

        // Five tms=1 from mid Shift-DR reaches TLR
        to_shift_dr();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        repeat (5) tick(1'b1, 1'b0);
        chk("tms5_ir_o",    32'(ir_o),      32'h1);
        chk("tms5_usr_upd", 32'(usr_upd_o), 32'h0);
        chk("tms5_bsr_upd", 32'(bsr_upd_o), 32'h0);
        chk("tms5_tdo_en",  32'(tdo_en),    32'd0);
        tick(1'b0, 1'b0);
        check_idcode("tms5_idcode");

        // rst_n pulse in the middle of Shift-IR
        load_ir(4'h0, irc);
        chk("extest_drive", 32'(bsr_drive_o), 32'd1);
        to_shift_ir();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_tdo_en", 32'(tdo_en), 32'd0);
        @(negedge tck);
        #1 rst_n = 1'b1;
        chk("midrst_ir_o",  32'(ir_o),        32'h1);
        chk("midrst_drive", 32'(bsr_drive_o), 32'd0);
        tick(1'b0, 1'b0);
        check_idcode("midrst_idcode");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
